// File: rtl/compare_unit.sv
// Multi-cycle magnitude comparator: scans operands one DIGIT-wide chunk per cycle, MSB chunk first,
// and stops at the first chunk that differs. Result is registered and flagged by a one-cycle done pulse.
module compare_unit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             out
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [KW-1:0]     r_k;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [2:0]        r_op;

  logic [WIDTH-1:0]  w_sign_flip;
  logic [DIGIT-1:0]  w_ca;
  logic [DIGIT-1:0]  w_cb;

  // Flipping the MSB maps two's-complement order onto unsigned order.
  assign w_sign_flip = {is_signed, {(WIDTH-1){1'b0}}};

  // Operands are shifted left as chunks match, so the active chunk is always on top.
  assign w_ca = r_a[WIDTH-1 -: DIGIT];
  assign w_cb = r_b[WIDTH-1 -: DIGIT];

  function automatic logic f_result(input logic [2:0] o, input logic lt, input logic gt,
                                    input logic eq);
    case (o)
      3'd0:    f_result = lt;
      3'd1:    f_result = lt | eq;
      3'd2:    f_result = eq;
      3'd3:    f_result = ~eq;
      3'd4:    f_result = gt;
      3'd5:    f_result = gt | eq;
      default: f_result = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      out     <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_ca != w_cb) begin
            out     <= f_result(r_op, w_ca < w_cb, w_ca > w_cb, 1'b0);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else if (r_k == LAST_K) begin
            out     <= f_result(r_op, 1'b0, 1'b0, 1'b1);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_k <= r_k + KW'(1);
            r_a <= r_a << DIGIT;
            r_b <= r_b << DIGIT;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= in1 ^ w_sign_flip;
            r_b     <= in2 ^ w_sign_flip;
            r_op    <= op;
            r_k     <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compare_unit.sv
// Scoreboard bench for compare_unit: driver pushes expected result/latency, monitor checks on done.
module tb_compare_unit;

  localparam int W = 32;
  localparam int D = 8;
  localparam int N = W / D;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [2:0]   op = '0;
  logic         is_signed = 1'b0;
  logic         busy, done, out;

  compare_unit #(.WIDTH(W), .DIGIT(D)) dut (
    .clock(clock), .reset(reset), .start(start), .in1(in1), .in2(in2),
    .op(op), .is_signed(is_signed), .busy(busy), .done(done), .out(out)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit exp_out;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   hold = 0;

  always @(posedge clock) cyc++;

  function automatic bit ref_out(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] o, input bit sgn);
    bit lt, gt, eq;
    eq = (a == b);
    lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
    gt = !lt && !eq;
    case (o)
      3'd0: return lt;
      3'd1: return lt || eq;
      3'd2: return eq;
      3'd3: return !eq;
      3'd4: return gt;
      3'd5: return gt || eq;
      default: return 1'b0;
    endcase
  endfunction

  // Cycles needed = position of the first differing chunk, counted from the top.
  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    x = a ^ b;
    for (int k = 0; k < N; k++)
      if (((x >> (W - (k + 1) * D)) & {{(W-D){1'b0}}, {D{1'b1}}}) != '0) return k + 1;
    return N;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: decoupled from the driver, pops one expectation per done pulse.
  bit prev_done = 0;
  bit last_out = 0;
  int busy_run = 0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      busy_run = 0;
      prev_done = 0;
      last_out = 0;
    end else begin
      if (done) begin
        chk("done_single_cycle", int'(prev_done), 0);
        chk("busy_in_done", int'(busy), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result", int'(out), int'(e.exp_out));
          chk("latency", cyc - e.acc, e.lat);
          chk("busy_cycles", busy_run, e.lat);
        end
        last_out = out;
      end else begin
        chk("out_stable", int'(out), int'(last_out));
      end
      busy_run = busy ? busy_run + 1 : 0;
      prev_done = done;
    end
  end

  // Called at a falling edge; the compare is accepted at the following rising edge.
  task automatic start_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] o, input bit sgn);
    exp_t e;
    in1 = a; in2 = b; op = o; is_signed = sgn; start = 1'b1;
    e.exp_out = ref_out(a, b, o, sgn);
    e.lat = ref_lat(a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    if (!hold) start = 1'b0;
  endtask

  // Returns at the falling edge where done is high. Under hold, start stays high and inputs churn.
  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      if (hold) begin
        in1 = $urandom; in2 = $urandom;
        op = 3'($urandom_range(0, 7)); is_signed = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    if (hold) start = 1'b0;
    hold = 0;
  endtask

  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] o, input bit sgn);
    start_cmp(a, b, o, sgn);
    wait_done();
  endtask

  initial begin
    logic [W-1:0] a, b;
    int k;
    #3;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_out", int'(out), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Started right after release: accepted on the first rising edge.
    run_cmp(32'hFFFFFFFF, 32'h00000001, 3'd0, 1'b1);
    run_cmp(32'hFFFFFFFF, 32'h00000001, 3'd0, 1'b0);
    @(negedge clock);
    run_cmp(32'h12345678, 32'h12345678, 3'd2, 1'b0);
    run_cmp(32'h12345678, 32'h12345678, 3'd3, 1'b0);
    run_cmp(32'h00000201, 32'h00000200, 3'd4, 1'b0);
    run_cmp(32'h00000201, 32'h00000200, 3'd1, 1'b0);
    run_cmp(32'h80000000, 32'h80000000, 3'd5, 1'b1);
    run_cmp(32'h00000005, 32'h00000009, 3'd6, 1'b0);
    @(negedge clock);

    // Start held high through RUN with churning inputs.
    hold = 1;
    run_cmp(32'hA5A5A5A5, 32'hA5A5A5A6, 3'd0, 1'b0);
    @(negedge clock);

    // Abort a 4-chunk compare two cycles in; out was 1 from the preceding EQ.
    run_cmp(32'hCAFEF00D, 32'hCAFEF00D, 3'd2, 1'b0);
    @(negedge clock);
    start_cmp(32'h11111111, 32'h11111111, 3'd2, 1'b0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_out", int'(out), 0);
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    run_cmp(32'h00000001, 32'h80000000, 3'd4, 1'b1);

    // Randomized, mostly back-to-back, with controlled first-differing chunk.
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = a;
      k = $urandom_range(0, N);
      if (k < N) begin
        b[W-1-D*k -: D] = b[W-1-D*k -: D] ^ D'($urandom_range(1, (1 << D) - 1));
        for (int j = k + 1; j < N; j++) b[W-1-D*j -: D] = D'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        logic [W-1:0] t;
        t = a; a = b; b = t;
      end
      hold = ($urandom_range(0, 4) == 0);
      run_cmp(a, b, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (6) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/compare_unit.md
COMPARE_UNIT -- requirements
Module: compare_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL provide parameter DIGIT, default 8, bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT; N = WIDTH/DIGIT.
REQ-003 SHALL provide port clock  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port start  input  1  request to begin a compare.
REQ-006 SHALL provide port in1  input  WIDTH  left operand.
REQ-007 SHALL provide port in2  input  WIDTH  right operand.
REQ-008 SHALL provide port op  input  3  0=LT, 1=LE, 2=EQ, 3=NE, 4=GT, 5=GE, 6/7 reserved.
REQ-009 SHALL provide port is_signed  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-010 SHALL provide port busy  output  1  high while a compare is in progress.
REQ-011 SHALL provide port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL provide port out  output  1  registered compare result.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; busy = 1 only in RUN; done = 1 only in DONE.
REQ-014 SHALL accept start only in IDLE or DONE; on acceptance at edge E, capture in1, in2, op, is_signed, set chunk index to 0 (most significant chunk), enter RUN.
REQ-015 SHALL ignore start while in RUN; captured operands SHALL not change until completion.
REQ-016 SHALL, when is_signed = 1, invert bit WIDTH-1 of both captured operands, then compare unsigned.
REQ-017 SHALL, each RUN cycle, compare chunk k of both operands (bits WIDTH-1-k*DIGIT down to WIDTH-(k+1)*DIGIT).
REQ-018 SHALL, on unequal chunk, record lt/gt from that chunk and enter DONE (early termination).
REQ-019 SHALL, on equal chunk with k < N-1, increment k and remain in RUN.
REQ-020 SHALL, on equal chunk with k = N-1, record equal and enter DONE.
REQ-021 SHALL update out on the edge entering DONE: LT=lt, LE=lt|eq, EQ=eq, NE=!eq, GT=gt, GE=gt|eq; reserved op codes yield out = 0.
REQ-022 SHALL have latency L = index of first differing chunk + 1, or N if operands equal; done high after edge E+L for exactly one cycle.
REQ-023 SHALL hold out stable from DONE until the next result is written.
REQ-024 SHALL leave DONE after one cycle: to RUN if start sampled, else to IDLE.
REQ-025 SHALL support back-to-back compares: start sampled during DONE begins a new compare with no idle cycle.

Reset
REQ-026 SHALL, while reset = 0, force state IDLE, busy = 0, done = 0, out = 0, chunk index 0, independent of clock.
REQ-027 SHALL abort any compare in progress on reset assertion; no done pulse for the aborted compare.
REQ-028 SHALL accept start on the first rising edge after reset deasserts.

Verification (WIDTH=32, DIGIT=8)
REQ-029 SHALL cover: signed LT, in1=0xFFFFFFFF, in2=0x00000001 -> out=1, done high after E+1 only.
REQ-030 SHALL cover: unsigned LT, same operands -> out=0, done after E+1.
REQ-031 SHALL cover: EQ, in1=in2=0x12345678 -> out=1, busy high 4 cycles, done after E+4; NE same operands -> out=0.
REQ-032 SHALL cover: GT, in1=0x00000201, in2=0x00000200 -> out=1 after E+4; LE same operands -> out=0; GE, in1=in2=0x80000000 signed -> out=1.
REQ-033 SHALL cover: reset asserted two cycles into a 4-chunk compare -> busy=0, done=0, out=0 immediately, no later done pulse; new start after release completes normally.
REQ-034 SHALL cover: start held high through RUN -> ignored; start during DONE -> second compare begins, done pulses at E2+L2 with out per new operands; op=6 -> out=0.
